// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - stall/exception request and pipeline control bundle
interface pipeline_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] exc_count;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, cnt_clr,
    input  stall, flush, new_pc, stall_cycles, exc_count
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, cnt_clr,
    output stall, flush, new_pc, stall_cycles, exc_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall merge, exception entry sequencing and debug counters
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000040,
  parameter logic [31:0] INT_VECTOR   = 32'h00000020
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_FREEZE, ST_FLUSH} state_t;

  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] CODE_INT   = 32'h00000001;
  localparam logic [31:0] CODE_ERET  = 32'h0000000e;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_flush_cnt;
  logic [3:0]  w_flush_cnt_nxt;
  logic [31:0] r_new_pc;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_exc_count;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic        w_exc_take;

  // Next-state and output decode; reset forces the pipeline controls low
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_stall         = 6'b000000;
    w_flush         = 1'b0;
    w_exc_take      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.excepttype_i != 32'd0) begin
          // Exception wins over every stall source, including a pending bus wait
          w_stall     = 6'b111111;
          w_exc_take  = 1'b1;
          w_state_nxt = ST_FREEZE;
        end else if (bus.stallreq_mem) begin
          w_stall = 6'b011111;
        end else if (bus.stallreq_ex) begin
          w_stall = 6'b001111;
        end else if (bus.stallreq_id) begin
          w_stall = 6'b000111;
        end
      end
      ST_FREEZE: begin
        // One quiet cycle so CP0 can commit EPC/Cause before the squash
        w_stall         = 6'b111111;
        w_flush_cnt_nxt = FLUSH_LOAD;
        w_state_nxt     = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    if (rst) begin
      w_stall = 6'b000000;
      w_flush = 1'b0;
    end
  end

  // State and flush-length counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Redirect target captured on exception entry, held until the next entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_pc <= 32'd0;
    end else if (w_exc_take) begin
      if (bus.excepttype_i == CODE_INT) begin
        r_new_pc <= INT_VECTOR;
      end else if (bus.excepttype_i == CODE_ERET) begin
        r_new_pc <= bus.cp0_epc_i;
      end else begin
        r_new_pc <= EXC_VECTOR;
      end
    end
  end

  // Debug counters: clear beats increment; stall count saturates, entry count wraps
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      r_stall_cycles <= 32'd0;
      r_exc_count    <= 16'd0;
    end else begin
      if (w_exc_take) begin
        r_exc_count <= r_exc_count + 16'd1;
      end
      if ((r_state == ST_RUN) && !w_exc_take && w_stall[0] &&
          (r_stall_cycles != 32'hFFFFFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.new_pc       = r_new_pc;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.exc_count    = r_exc_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [15:0] ec;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  pipeline_ctrl_if bus1 ();
  pipeline_ctrl_if bus3 ();

  pipeline_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipeline_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel3, input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    if (sel3) begin
      bus3.stallreq_id = id; bus3.stallreq_ex = ex; bus3.stallreq_mem = mem;
      bus3.excepttype_i = exc; bus3.cp0_epc_i = epc; bus3.cnt_clr = clr;
    end else begin
      bus1.stallreq_id = id; bus1.stallreq_ex = ex; bus1.stallreq_mem = mem;
      bus1.excepttype_i = exc; bus1.cp0_epc_i = epc; bus1.cnt_clr = clr;
    end
  endtask

  task automatic step(input string nm, input bit sel3, input logic [5:0] st, input logic fl,
                      input logic [31:0] pc, input logic [31:0] sc, input logic [15:0] ec);
    exp_t e;
    e.st = st; e.fl = fl; e.pc = pc; e.sc = sc; e.ec = ec;
    sb.push_back(e);
    #4;
    e = sb.pop_front();
    if (sel3) begin
      chk({nm, ".stall"}, {26'd0, bus3.stall}, {26'd0, e.st});
      chk({nm, ".flush"}, {31'd0, bus3.flush}, {31'd0, e.fl});
      chk({nm, ".new_pc"}, bus3.new_pc, e.pc);
      chk({nm, ".stall_cycles"}, bus3.stall_cycles, e.sc);
      chk({nm, ".exc_count"}, {16'd0, bus3.exc_count}, {16'd0, e.ec});
    end else begin
      chk({nm, ".stall"}, {26'd0, bus1.stall}, {26'd0, e.st});
      chk({nm, ".flush"}, {31'd0, bus1.flush}, {31'd0, e.fl});
      chk({nm, ".new_pc"}, bus1.new_pc, e.pc);
      chk({nm, ".stall_cycles"}, bus1.stall_cycles, e.sc);
      chk({nm, ".exc_count"}, {16'd0, bus1.exc_count}, {16'd0, e.ec});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;

    // reset: request during reset must not reach stall
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    step("rst_hold", 1'b0, 6'h00, 1'b0, 32'h0, 32'd0, 16'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("idle0", 1'b0, 6'h00, 1'b0, 32'h0, 32'd0, 16'd0);
    step("idle1", 1'b0, 6'h00, 1'b0, 32'h0, 32'd0, 16'd0);

    // stall priority
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("st_id", 1'b0, 6'h07, 1'b0, 32'h0, 32'd0, 16'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    step("st_ex", 1'b0, 6'h0f, 1'b0, 32'h0, 32'd1, 16'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
    step("st_mem", 1'b0, 6'h1f, 1'b0, 32'h0, 32'd2, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("st_hold", 1'b0, 6'h1f, 1'b0, 32'h0, 32'(3 + i), 16'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("st_cnt", 1'b0, 6'h00, 1'b0, 32'h0, 32'd6, 16'd0);

    // overflow exception with a MEM stall pending
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000c, 32'd0, 1'b0);
    step("ov_T", 1'b0, 6'h3f, 1'b0, 32'h0, 32'd6, 16'd0);
    step("ov_T1", 1'b0, 6'h3f, 1'b0, 32'h40, 32'd6, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    step("ov_T2", 1'b0, 6'h00, 1'b1, 32'h40, 32'd6, 16'd1);
    step("ov_T3", 1'b0, 6'h1f, 1'b0, 32'h40, 32'd6, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("ov_idle", 1'b0, 6'h00, 1'b0, 32'h40, 32'd7, 16'd1);

    // eret: EPC sampled in the entry cycle only
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000000e, 32'h00400104, 1'b0);
    step("eret_T", 1'b0, 6'h3f, 1'b0, 32'h40, 32'd7, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("eret_T1", 1'b0, 6'h3f, 1'b0, 32'h00400104, 32'd7, 16'd2);
    step("eret_T2", 1'b0, 6'h00, 1'b1, 32'h00400104, 32'd7, 16'd2);
    step("eret_T3", 1'b0, 6'h00, 1'b0, 32'h00400104, 32'd7, 16'd2);

    // counter clear beats a same-cycle increment
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("clr_a", 1'b0, 6'h07, 1'b0, 32'h00400104, 32'd7, 16'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step("clr_b", 1'b0, 6'h07, 1'b0, 32'h00400104, 32'd8, 16'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("clr_c", 1'b0, 6'h00, 1'b0, 32'h00400104, 32'd0, 16'd0);

    // saturation from a preloaded near-max count
    force dut1.r_stall_cycles = 32'hFFFFFFFE;
    #1;
    release dut1.r_stall_cycles;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("sat_a", 1'b0, 6'h07, 1'b0, 32'h00400104, 32'hFFFFFFFE, 16'd0);
    step("sat_b", 1'b0, 6'h07, 1'b0, 32'h00400104, 32'hFFFFFFFF, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("sat_c", 1'b0, 6'h00, 1'b0, 32'h00400104, 32'hFFFFFFFF, 16'd0);

    // three-cycle flush with an interrupt; entry attempts in FREEZE/FLUSH ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'd0, 1'b0);
    step("int_T", 1'b1, 6'h3f, 1'b0, 32'h0, 32'd0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000000c, 32'd0, 1'b0);
    step("int_frz", 1'b1, 6'h3f, 1'b0, 32'h20, 32'd0, 16'd1);
    step("int_fl1", 1'b1, 6'h00, 1'b1, 32'h20, 32'd0, 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'd0, 1'b0);
    step("int_fl2", 1'b1, 6'h00, 1'b1, 32'h20, 32'd0, 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    step("int_fl3", 1'b1, 6'h00, 1'b1, 32'h20, 32'd0, 16'd1);
    step("int_run", 1'b1, 6'h1f, 1'b0, 32'h20, 32'd0, 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("int_idle", 1'b1, 6'h00, 1'b0, 32'h20, 32'd1, 16'd1);

    // reset during the first flush cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000000c, 32'd0, 1'b0);
    step("rf_T", 1'b1, 6'h3f, 1'b0, 32'h20, 32'd1, 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("rf_frz", 1'b1, 6'h3f, 1'b0, 32'h40, 32'd1, 16'd2);
    rst = 1'b1;
    step("rf_rst", 1'b1, 6'h00, 1'b0, 32'h40, 32'd1, 16'd2);
    rst = 1'b0;
    step("rf_after", 1'b1, 6'h00, 1'b0, 32'h0, 32'd0, 16'd0);
    step("rf_quiet", 1'b1, 6'h00, 1'b0, 32'h0, 32'd0, 16'd0);

    // exception in the first RUN cycle after a flush is taken
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000000c, 32'd0, 1'b0);
    step("bb_T", 1'b1, 6'h3f, 1'b0, 32'h0, 32'd0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("bb_frz", 1'b1, 6'h3f, 1'b0, 32'h40, 32'd0, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step("bb_fl", 1'b1, 6'h00, 1'b1, 32'h40, 32'd0, 16'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'd0, 1'b0);
    step("bb_T2", 1'b1, 6'h3f, 1'b0, 32'h40, 32'd0, 16'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step("bb_frz2", 1'b1, 6'h3f, 1'b0, 32'h20, 32'd0, 16'd2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
